fast_ring_fetch: RTL and testbench
==================================

FAST_RING_FETCH -- requirements
Module: fast_ring_fetch

Interface
REQ-001 SHALL have parameter PIXEL_DEPTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter X_MAX, default 16, image width in pixels.
REQ-003 SHALL have parameter Y_MAX, default 16, image height in pixels.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port n_rst  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port start  input  1  request to fetch one neighbourhood.
REQ-007 SHALL have port cx  input  signed $clog2(X_MAX)+1  centre column.
REQ-008 SHALL have port cy  input  signed $clog2(Y_MAX)+1  centre row.
REQ-009 SHALL have port x_addr  output  signed $clog2(X_MAX)+1  column to the image SRAM.
REQ-010 SHALL have port y_addr  output  signed $clog2(Y_MAX)+1  row to the image SRAM.
REQ-011 SHALL have port ren  output  1  read enable to the image SRAM.
REQ-012 SHALL have port rdat  input  PIXEL_DEPTH  SRAM read data, valid the cycle after ren.
REQ-013 SHALL have port busy  output  1  fetch in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port center  output  PIXEL_DEPTH  centre pixel.
REQ-016 SHALL have port ring  output  16*PIXEL_DEPTH  ring pixels; slot k at bits [k*PIXEL_DEPTH +: PIXEL_DEPTH].

Function
REQ-017 SHALL fetch 17 pixels in order: the centre, then ring slots 0..15.
REQ-018 Ring offsets (dx,dy), slots 0..15, SHALL be (0,-3),(1,-3),(2,-2),(3,-1),(3,0),(3,1),(2,2),(1,3),(0,3),(-1,3),(-2,2),(-3,1),(-3,0),(-3,-1),(-2,-2),(-1,-3).
REQ-019 SHALL implement the states IDLE, FETCH, DRAIN and DONE.
REQ-020 IDLE: start=1 SHALL latch cx/cy, clear the issue index and go to FETCH; start SHALL be ignored in every other state.
REQ-021 FETCH SHALL last exactly 17 cycles, issuing one address per cycle for index 0..16, then go to DRAIN.
REQ-022 DRAIN SHALL last 1 cycle, with ren=0, and capture the index-16 data; the next state SHALL be DONE.
REQ-023 DONE SHALL last 1 cycle, with done=1, and return to IDLE.
REQ-024 busy SHALL be 1 in FETCH and DRAIN, and 0 otherwise; done SHALL be 1 only in DONE.
REQ-025 The data for the index issued in cycle n SHALL be registered from rdat at the end of cycle n+1.
REQ-026 Coordinates SHALL be computed as latched centre + offset at width+2 bits; a coordinate is out of bounds (OOB) if <0 or >X_MAX-1 (column), or <0 or >Y_MAX-1 (row).
REQ-027 x_addr/y_addr SHALL carry the low bits of the computed coordinate during FETCH, and hold at 0 otherwise.
REQ-028 ren SHALL be 1 during FETCH for in-bounds indices and 0 for OOB indices and in all other states.
REQ-029 An OOB index SHALL capture 0, and rdat SHALL be ignored for it.
REQ-030 center/ring SHALL hold their values from DONE until the next accepted start; they SHALL NOT be cleared by start.
REQ-031 start held high through DONE SHALL launch a new fetch only on the first cycle in IDLE.

Reset
REQ-032 n_rst=0 at a clock edge SHALL force IDLE; busy, done, ren, x_addr, y_addr, center and ring SHALL all be 0.
REQ-033 Reset asserted in any state SHALL abort the fetch with no done pulse, and ren SHALL be 0 from the following cycle.

Verification
REQ-034 Image 16x16, pixel=x+16*y, start with (8,8) -> center=0x88, ring0=0x58, ring4=0x8B, ring8=0xB8, ring12=0x85, ring2=0x6A.
REQ-035 Timing: start accepted at edge 0 -> ren high for cycles 1..17, DRAIN at cycle 18, done=1 only at cycle 19, busy high for cycles 1..18.
REQ-036 Corner (1,1) -> ring0=0 and ring12=0 (ren low in those slots); ring4=0x14, center=0x11.
REQ-037 Corner (15,15) -> ring4 (18,15)=0 with no wrap, ring0=0xCF, ring8=0.
REQ-038 A second start pulsed at FETCH cycle 5 -> ignored, exactly one done, results match the first centre.
REQ-039 n_rst low at FETCH cycle 5 -> ren=0 next cycle, no done, all outputs 0, next start behaves as REQ-035.

Source files
------------

// File: rtl/fast_ring_fetch.sv
// fast_ring_fetch: reads a centre pixel plus its 16-pixel radius-3 ring
// from an image SRAM, one address per cycle, and presents them in parallel.
// Ports:
//   clk, n_rst (sync, active-low)
//   start, cx, cy       : fetch request and centre coordinate
//   x_addr, y_addr, ren : SRAM read port (data on rdat one cycle later)
//   busy, done          : status; done pulses once per completed fetch
//   center, ring        : fetched pixels, ring slot k at [k*PD +: PD]
module fast_ring_fetch #(
  parameter int PIXEL_DEPTH = 8,
  parameter int X_MAX       = 16,
  parameter int Y_MAX       = 16
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start,
  input  logic signed [$clog2(X_MAX):0]  cx,
  input  logic signed [$clog2(Y_MAX):0]  cy,
  output logic signed [$clog2(X_MAX):0]  x_addr,
  output logic signed [$clog2(Y_MAX):0]  y_addr,
  output logic                           ren,
  input  logic [PIXEL_DEPTH-1:0]         rdat,
  output logic                           busy,
  output logic                           done,
  output logic [PIXEL_DEPTH-1:0]         center,
  output logic [16*PIXEL_DEPTH-1:0]      ring
);

  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;
  localparam int PD = PIXEL_DEPTH;

  localparam logic signed [XW+1:0] X_LIM = (XW+2)'(X_MAX - 1);
  localparam logic signed [YW+1:0] Y_LIM = (YW+2)'(Y_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic signed [XW-1:0] r_cx;
  logic signed [YW-1:0] r_cy;
  logic [4:0]           r_idx;

  logic                 r_pv;
  logic [4:0]           r_pidx;
  logic                 r_poob;

  logic [PD-1:0]        r_center;
  logic [16*PD-1:0]     r_ring;

  logic signed [2:0]    w_dx;
  logic signed [2:0]    w_dy;
  logic signed [XW+1:0] w_x;
  logic signed [YW+1:0] w_y;
  logic                 w_oob;
  logic                 w_accept;
  logic [PD-1:0]        w_cap;

  // Index 0 is the centre; index k+1 is ring slot k.
  always_comb begin
    w_dx = 3'sd0;
    w_dy = 3'sd0;
    case (r_idx)
      5'd1:  begin w_dx =  3'sd0; w_dy = -3'sd3; end
      5'd2:  begin w_dx =  3'sd1; w_dy = -3'sd3; end
      5'd3:  begin w_dx =  3'sd2; w_dy = -3'sd2; end
      5'd4:  begin w_dx =  3'sd3; w_dy = -3'sd1; end
      5'd5:  begin w_dx =  3'sd3; w_dy =  3'sd0; end
      5'd6:  begin w_dx =  3'sd3; w_dy =  3'sd1; end
      5'd7:  begin w_dx =  3'sd2; w_dy =  3'sd2; end
      5'd8:  begin w_dx =  3'sd1; w_dy =  3'sd3; end
      5'd9:  begin w_dx =  3'sd0; w_dy =  3'sd3; end
      5'd10: begin w_dx = -3'sd1; w_dy =  3'sd3; end
      5'd11: begin w_dx = -3'sd2; w_dy =  3'sd2; end
      5'd12: begin w_dx = -3'sd3; w_dy =  3'sd1; end
      5'd13: begin w_dx = -3'sd3; w_dy =  3'sd0; end
      5'd14: begin w_dx = -3'sd3; w_dy = -3'sd1; end
      5'd15: begin w_dx = -3'sd2; w_dy = -3'sd2; end
      5'd16: begin w_dx = -3'sd1; w_dy = -3'sd3; end
      default: begin w_dx = 3'sd0; w_dy = 3'sd0; end
    endcase
  end

  // Two guard bits keep centre+offset from wrapping.
  assign w_x = {{2{r_cx[XW-1]}}, r_cx}
             + {{(XW-1){w_dx[2]}}, w_dx};
  assign w_y = {{2{r_cy[YW-1]}}, r_cy}
             + {{(YW-1){w_dy[2]}}, w_dy};

  assign w_oob = w_x[XW+1] || (w_x > X_LIM)
              || w_y[YW+1] || (w_y > Y_LIM);

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_cap    = r_poob ? '0 : rdat;

  always_comb begin
    w_state_nx = r_state;
    ren        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    x_addr     = '0;
    y_addr     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nx = S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        ren    = !w_oob;
        x_addr = w_x[XW-1:0];
        y_addr = w_y[YW-1:0];
        if (r_idx == 5'd16) w_state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy       = 1'b1;
        w_state_nx = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_cx  <= cx;
        r_cy  <= cy;
        r_idx <= '0;
      end else if (r_state == S_FETCH) begin
        r_idx <= r_idx + 5'd1;
      end
    end
  end

  // rdat answers the address issued one cycle earlier, so the
  // issue index and its OOB flag travel one stage behind.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_pv     <= 1'b0;
      r_pidx   <= '0;
      r_poob   <= 1'b0;
      r_center <= '0;
      r_ring   <= '0;
    end else begin
      r_pv   <= (r_state == S_FETCH);
      r_pidx <= r_idx;
      r_poob <= w_oob;
      if (r_pv) begin
        if (r_pidx == 5'd0) r_center <= w_cap;
        for (int k = 0; k < 16; k++) begin
          if (r_pidx == 5'(k + 1))
            r_ring[k*PD +: PD] <= w_cap;
        end
      end
    end
  end

  assign center = r_center;
  assign ring   = r_ring;

endmodule

// File: tb/tb_fast_ring_fetch.sv
// tb_fast_ring_fetch: table vectors, timing/corner sequences and
// randomized fetches against a coordinate-level reference model.
module tb_fast_ring_fetch;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              start;
  logic signed [4:0] cx, cy;
  logic signed [4:0] x_addr, y_addr;
  logic              ren, busy, done;
  logic [7:0]        rdat, center;
  logic [127:0]      ring;

  always #5 clk = ~clk;

  fast_ring_fetch #(
    .PIXEL_DEPTH(8), .X_MAX(16), .Y_MAX(16)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .cx(cx), .cy(cy),
    .x_addr(x_addr), .y_addr(y_addr), .ren(ren),
    .rdat(rdat), .busy(busy), .done(done),
    .center(center), .ring(ring)
  );

  logic [7:0] mem [16][16];
  int vecs = 0;
  int errs = 0;

  int dxs [17] = '{0, 0, 1, 2, 3, 3, 3, 2, 1, 0,-1,-2,-3,-3,-3,-2,-1};
  int dys [17] = '{0,-3,-3,-2,-1, 0, 1, 2, 3, 3, 3, 2, 1, 0,-1,-2,-3};

  // SRAM: one-cycle read latency, garbage when not enabled.
  always @(posedge clk) begin
    if (ren) rdat <= mem[y_addr[3:0]][x_addr[3:0]];
    else     rdat <= 8'($urandom);
  end

  function automatic bit inb(int x, int y);
    return x >= 0 && x < 16 && y >= 0 && y < 16;
  endfunction

  function automatic logic [7:0] pix(int x, int y);
    return inb(x, y) ? mem[y][x] : 8'h00;
  endfunction

  function automatic logic [127:0] exp_ring(int x, int y);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      r[k*8 +: 8] = pix(x + dxs[k+1], y + dys[k+1]);
    return r;
  endfunction

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_lin();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        mem[y][x] = 8'(x + 16*y);
  endtask

  task automatic fill_rand();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        mem[y][x] = 8'($urandom);
  endtask

  // One fetch of (x,y); checks every cycle's handshake/address.
  // rs_cyc: cycle of a second start pulse; rst_cyc: cycle reset is driven.
  task automatic fetch(int x, int y, int rs_cyc, int rst_cyc);
    int nd;
    int xx, yy;
    bit eren, ebusy, edone;
    logic [4:0] exa, eya;
    nd = 0;
    @(negedge clk);
    cx = 5'(x); cy = 5'(y); start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (rst_cyc >= 0 && c > rst_cyc) begin
        check($sformatf("rst_cyc%0d", c),
              {ren, busy, done, x_addr, y_addr, center, ring},
              '0);
        if (done) nd++;
        if (c == rst_cyc + 1) n_rst = 1'b1;
        if (c == rst_cyc + 2) break;
      end else begin
        ebusy = (c <= 18);
        edone = (c == 19);
        eren  = 1'b0;
        exa   = '0;
        eya   = '0;
        if (c <= 17) begin
          xx   = x + dxs[c-1];
          yy   = y + dys[c-1];
          eren = inb(xx, yy);
          exa  = 5'(xx);
          eya  = 5'(yy);
        end
        check($sformatf("cyc%0d(%0d,%0d)", c, x, y),
              {ren, busy, done, x_addr, y_addr},
              {eren, ebusy, edone, exa, eya});
        if (done) nd++;
        if (c == rst_cyc) n_rst = 1'b0;
      end
      if (c == rs_cyc) begin
        start = 1'b1; cx = 5'd0; cy = 5'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (rst_cyc >= 0) begin
      check("rst_nodone", 128'(nd), 128'd0);
    end else begin
      check("done_cnt", 128'(nd), 128'd1);
      check("center", 128'(center), 128'(pix(x, y)));
      check("ring", ring, exp_ring(x, y));
    end
  endtask

  typedef struct {
    int x, y;
    logic [7:0] c, r0, r2, r4, r8, r12;
  } vec_t;

  vec_t tbl [3];
  int d1, d2;

  initial begin
    tbl[0] = '{8, 8, 8'h88, 8'h58, 8'h6A, 8'h8B, 8'hB8, 8'h85};
    tbl[1] = '{1, 1, 8'h11, 8'h00, 8'h00, 8'h14, 8'h41, 8'h00};
    tbl[2] = '{15, 15, 8'hFF, 8'hCF, 8'h00, 8'h00, 8'h00, 8'hFC};

    n_rst = 1'b0; start = 1'b0; cx = '0; cy = '0;
    fill_lin();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          {ren, busy, done, x_addr, y_addr, center, ring}, '0);
    n_rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      fetch(tbl[i].x, tbl[i].y, -1, -1);
      check($sformatf("t%0d_c", i), 128'(center), 128'(tbl[i].c));
      check($sformatf("t%0d_r0", i), 128'(ring[0*8 +: 8]), 128'(tbl[i].r0));
      check($sformatf("t%0d_r2", i), 128'(ring[2*8 +: 8]), 128'(tbl[i].r2));
      check($sformatf("t%0d_r4", i), 128'(ring[4*8 +: 8]), 128'(tbl[i].r4));
      check($sformatf("t%0d_r8", i), 128'(ring[8*8 +: 8]), 128'(tbl[i].r8));
      check($sformatf("t%0d_r12", i), 128'(ring[12*8 +: 8]), 128'(tbl[i].r12));
    end

    // Second start mid-fetch is ignored.
    fetch(5, 9, 5, -1);

    // Reset during FETCH, then a clean fetch.
    fetch(8, 8, -1, 5);
    fetch(8, 8, -1, -1);

    // start held high: relaunch only on the first IDLE cycle.
    d1 = 0; d2 = 0;
    @(negedge clk);
    cx = 5'd7; cy = 5'd6; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done && d1 == 0) d1 = c;
      else if (done) d2 = c;
      if (c == 40) start = 1'b0;
    end
    check("hold_done1", 128'(d1), 128'd19);
    check("hold_done2", 128'(d2), 128'd39);
    check("hold_center", 128'(center), 128'(pix(7, 6)));

    // Random images and centres, including off-image centres.
    for (int i = 0; i < 20; i++) begin
      int rx, ry;
      fill_rand();
      rx = int'($urandom_range(0, 18)) - 3;
      ry = int'($urandom_range(0, 18)) - 3;
      fetch(rx, ry, -1, -1);
      cx = 5'($urandom); cy = 5'($urandom);
      repeat (3) @(negedge clk);
      check($sformatf("hold_c%0d", i), 128'(center), 128'(pix(rx, ry)));
      check($sformatf("hold_r%0d", i), ring, exp_ring(rx, ry));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
